// File: rtl/tile_shift_engine.sv
// Sliding-tile board engine: one line compacted and merged per cycle,
// whole board committed atomically when the move finishes.
module tile_shift_engine #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int TW   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    input  logic [1:0]             cmd_dir,
    output logic                   cmd_ready,
    input  logic                   load_valid,
    input  logic [ROWS*COLS*TW-1:0] load_board,
    output logic [ROWS*COLS*TW-1:0] board,
    output logic                   busy,
    output logic                   done,
    output logic                   moved,
    output logic [7:0]             merge_cnt
);

    localparam int N    = ROWS * COLS;
    localparam int MAXL = (ROWS > COLS) ? ROWS : COLS;
    localparam logic [TW-1:0] SAT = '1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [1:0]      dir;
    logic [3:0]      line;
    logic [3:0]      line_cnt;
    logic            last_line;
    logic            accept;
    logic [N*TW-1:0] work, work_nxt;
    logic [7:0]      merge_acc;
    logic [7:0]      line_merges;

    logic [TW-1:0] src [MAXL];
    logic [TW-1:0] cmp [MAXL+1];
    logic [TW-1:0] res [MAXL];
    int            len, n, o, pos;
    logic          skip;

    // Flat tile index of the i-th cell of line j, counted from the
    // destination edge outward.
    function automatic int tile_pos(input logic [1:0] d, input int j, input int i);
        int r, c;
        case (d)
            2'd0:    begin r = i;          c = j;          end
            2'd1:    begin r = ROWS - 1 - i; c = j;        end
            2'd2:    begin r = j;          c = i;          end
            default: begin r = j;          c = COLS - 1 - i; end
        endcase
        return r * COLS + c;
    endfunction

    assign line_cnt  = dir[1] ? 4'(ROWS) : 4'(COLS);
    assign last_line = (line == line_cnt - 4'd1);
    assign accept    = cmd_valid && cmd_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = rst_n && !load_valid;
                if (cmd_valid && rst_n && !load_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_line) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Compact and merge the current line of the working board.
    always_comb begin
        work_nxt    = work;
        line_merges = '0;
        len         = dir[1] ? COLS : ROWS;
        n           = 0;
        o           = 0;
        pos         = 0;
        skip        = 1'b0;
        for (int i = 0; i < MAXL; i++) begin
            src[i] = '0;
            res[i] = '0;
        end
        for (int i = 0; i <= MAXL; i++) cmp[i] = '0;
        for (int i = 0; i < MAXL; i++) begin
            if (i < len) begin
                pos = tile_pos(dir, int'(line), i);
                if (pos < N) src[i] = work[pos*TW +: TW];
            end
        end
        for (int i = 0; i < MAXL; i++) begin
            if (src[i] != '0) begin
                cmp[n] = src[i];
                n      = n + 1;
            end
        end
        for (int i = 0; i < MAXL; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (i < n) begin
                if (i + 1 < n && cmp[i] == cmp[i+1] && cmp[i] != SAT) begin
                    res[o]      = cmp[i] + TW'(1);
                    skip        = 1'b1;
                    line_merges = line_merges + 8'd1;
                end else begin
                    res[o] = cmp[i];
                end
                o = o + 1;
            end
        end
        for (int i = 0; i < MAXL; i++) begin
            if (i < len) begin
                pos = tile_pos(dir, int'(line), i);
                if (pos < N) work_nxt[pos*TW +: TW] = res[i];
            end
        end
    end

    // Board, working copy and move result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board     <= '0;
            work      <= '0;
            dir       <= '0;
            line      <= '0;
            merge_acc <= '0;
            moved     <= 1'b0;
            merge_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_valid) begin
                        board     <= load_board;
                        moved     <= 1'b0;
                        merge_cnt <= '0;
                    end else if (accept) begin
                        dir       <= cmd_dir;
                        work      <= board;
                        line      <= '0;
                        merge_acc <= '0;
                    end
                end
                SHIFT: begin
                    work      <= work_nxt;
                    merge_acc <= merge_acc + line_merges;
                    if (!last_line) line <= line + 4'd1;
                end
                DONE: begin
                    board     <= work;
                    moved     <= (work != board);
                    merge_cnt <= merge_acc;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_shift_engine.sv
// Bench for tile_shift_engine: directed vector table, hand-written
// corner sequences and randomized moves against a queue-based model.
module tb_tile_shift_engine;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int TW   = 4;
    localparam int BW   = ROWS * COLS * TW;

    typedef logic [BW-1:0] bd_t;

    typedef struct {
        bd_t        bi;
        logic [1:0] d;
        bd_t        be;
        logic       mv;
        int         mg;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_dir = 2'd0;
    logic       load_valid = 1'b0;
    bd_t        load_board = '0;
    logic       cmd_ready, busy, done, moved;
    bd_t        board;
    logic [7:0] merge_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tile_shift_engine #(.ROWS(ROWS), .COLS(COLS), .TW(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_dir    (cmd_dir),
        .cmd_ready  (cmd_ready),
        .load_valid (load_valid),
        .load_board (load_board),
        .board      (board),
        .busy       (busy),
        .done       (done),
        .moved      (moved),
        .merge_cnt  (merge_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bd_t set_tile(input bd_t b, input int r, input int c, input int v);
        b[(r*COLS+c)*TW +: TW] = TW'(v);
        return b;
    endfunction

    function automatic bd_t row0(input int a, input int b, input int c, input int d);
        bd_t x = '0;
        x = set_tile(x, 0, 0, a);
        x = set_tile(x, 0, 1, b);
        x = set_tile(x, 0, 2, c);
        x = set_tile(x, 0, 3, d);
        return x;
    endfunction

    function automatic bd_t col0(input int a, input int b, input int c, input int d);
        bd_t x = '0;
        x = set_tile(x, 0, 0, a);
        x = set_tile(x, 1, 0, b);
        x = set_tile(x, 2, 0, c);
        x = set_tile(x, 3, 0, d);
        return x;
    endfunction

    // Cell k of line j for direction d, k counted from the wall tiles slide to.
    function automatic void coord(input int d, input int j, input int k,
                                  output int r, output int c);
        case (d)
            0:       begin r = k;            c = j;            end
            1:       begin r = ROWS - 1 - k; c = j;            end
            2:       begin r = j;            c = k;            end
            default: begin r = j;            c = COLS - 1 - k; end
        endcase
    endfunction

    function automatic void ref_move(input bd_t bi, input int d,
                                     output bd_t bo, output int mg);
        int g[ROWS][COLS];
        int q[$];
        int m[$];
        int nl, len, r, c, k;
        for (int rr = 0; rr < ROWS; rr++)
            for (int cc = 0; cc < COLS; cc++)
                g[rr][cc] = int'(bi[(rr*COLS+cc)*TW +: TW]);
        mg  = 0;
        nl  = (d < 2) ? COLS : ROWS;
        len = (d < 2) ? ROWS : COLS;
        for (int j = 0; j < nl; j++) begin
            q = {};
            m = {};
            for (int kk = 0; kk < len; kk++) begin
                coord(d, j, kk, r, c);
                if (g[r][c] != 0) q.push_back(g[r][c]);
            end
            k = 0;
            while (k < q.size()) begin
                if (k + 1 < q.size() && q[k] == q[k+1] && q[k] != (1 << TW) - 1) begin
                    m.push_back(q[k] + 1);
                    mg++;
                    k += 2;
                end else begin
                    m.push_back(q[k]);
                    k++;
                end
            end
            for (int kk = 0; kk < len; kk++) begin
                coord(d, j, kk, r, c);
                g[r][c] = (kk < m.size()) ? m[kk] : 0;
            end
        end
        bo = '0;
        for (int rr = 0; rr < ROWS; rr++)
            for (int cc = 0; cc < COLS; cc++)
                bo = set_tile(bo, rr, cc, g[rr][cc]);
    endfunction

    function automatic bd_t rand_board();
        bd_t b = '0;
        int  s, v;
        for (int i = 0; i < ROWS * COLS; i++) begin
            s = int'($urandom_range(0, 9));
            if (s < 4)       v = 0;
            else if (s < 8)  v = int'($urandom_range(1, 3));
            else if (s == 8) v = 15;
            else             v = int'($urandom_range(4, 14));
            b[i*TW +: TW] = TW'(v);
        end
        return b;
    endfunction

    task automatic load(input bd_t b);
        @(negedge clk);
        load_valid = 1'b1;
        load_board = b;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
    endtask

    // poke: 0 none, 1 cmd_valid during SHIFT, 2 load_valid during SHIFT
    task automatic run_move(input logic [1:0] d, input int poke,
                            output int lat, output int bsy);
        bd_t old;
        int  l;
        l   = (d < 2) ? COLS : ROWS;
        old = board;
        @(negedge clk);
        cmd_dir   = d;
        cmd_valid = 1'b1;
        #1;
        chk("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        lat = 0;
        bsy = busy ? 1 : 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            cmd_valid  = 1'b0;
            load_valid = 1'b0;
            if (done) break;
            if (busy) bsy++;
            if (lat == l) chk("hold_precommit", board, old);
            if (poke == 1 && lat == 2) begin
                cmd_valid = 1'b1;
                cmd_dir   = d ^ 2'd1;
            end
            if (poke == 2 && lat == 2) begin
                load_valid = 1'b1;
                load_board = '1;
            end
        end
        cmd_valid  = 1'b0;
        load_valid = 1'b0;
        if (!done) chk("done_timeout", 0, 1);
        @(posedge clk);
        #1;
        chk("done_one_cycle", done, 0);
    endtask

    vec_t tv[7];

    initial begin
        int  lat, bsy, l, mg, cnt;
        bd_t exp_b, b;
        logic [1:0] d;

        tv[0] = '{row0(1,1,1,0), 2'd2, row0(2,1,0,0), 1'b1, 1};
        tv[1] = '{row0(2,2,2,2), 2'd3, row0(0,0,3,3), 1'b1, 2};
        tv[2] = '{row0(1,2,3,4), 2'd2, row0(1,2,3,4), 1'b0, 0};
        tv[3] = '{row0(15,15,0,0), 2'd2, row0(15,15,0,0), 1'b0, 0};
        tv[4] = '{col0(0,1,0,1), 2'd0, col0(2,0,0,0), 1'b1, 1};
        tv[5] = '{col0(0,1,0,1), 2'd1, col0(0,0,0,2), 1'b1, 1};
        tv[6] = '{row0(1,1,1,0), 2'd3, row0(0,0,1,2), 1'b1, 1};

        #2;
        chk("rst_board", board, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_moved", moved, 0);
        chk("rst_merge", merge_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", cmd_ready, 1);

        for (int i = 0; i < 7; i++) begin
            load(tv[i].bi);
            run_move(tv[i].d, 0, lat, bsy);
            l = (tv[i].d < 2) ? COLS : ROWS;
            chk("vec_board", board, tv[i].be);
            chk("vec_moved", moved, tv[i].mv);
            chk("vec_merge", merge_cnt, tv[i].mg);
            chk("vec_latency", lat, l + 1);
            chk("vec_busy_cycles", bsy, l + 1);
        end

        for (int i = 0; i < 40; i++) begin
            b = rand_board();
            d = 2'($urandom_range(0, 3));
            ref_move(b, int'(d), exp_b, mg);
            load(b);
            run_move(d, 0, lat, bsy);
            chk("rand_board", board, exp_b);
            chk("rand_moved", moved, exp_b != b);
            chk("rand_merge", merge_cnt, mg);
            chk("rand_latency", lat, 5);
        end

        load(row0(1,1,0,0));
        run_move(2'd2, 0, lat, bsy);
        chk("pre_cont_moved", moved, 1);
        @(negedge clk);
        load_board = row0(3,0,0,3);
        load_valid = 1'b1;
        cmd_valid  = 1'b1;
        cmd_dir    = 2'd2;
        #1;
        chk("cont_ready_low", cmd_ready, 0);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        cmd_valid  = 1'b0;
        chk("cont_board", board, row0(3,0,0,3));
        chk("cont_moved_clr", moved, 0);
        chk("cont_merge_clr", merge_cnt, 0);
        cnt = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done || busy) cnt++;
        end
        chk("cont_no_move", cnt, 0);

        load(row0(1,1,0,0));
        run_move(2'd2, 1, lat, bsy);
        chk("cmd_in_shift_board", board, row0(2,0,0,0));
        cnt = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done || busy) cnt++;
        end
        chk("cmd_in_shift_noqueue", cnt, 0);

        load(row0(0,0,2,2));
        run_move(2'd3, 2, lat, bsy);
        chk("load_in_shift_board", board, row0(0,0,0,3));
        chk("load_in_shift_merge", merge_cnt, 1);

        load(row0(1,1,1,0));
        @(negedge clk);
        cmd_dir   = 2'd2;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_board", board, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cmd_ready, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_ready_rise", cmd_ready, 1);
        cnt = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done || board != '0) cnt++;
        end
        chk("mid_rst_no_commit", cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tile_shift_engine.md
TILE_SHIFT_ENGINE -- requirements
Module: tile_shift_engine

Interface
REQ-001 SHALL have parameter ROWS, default 4, board row count (2..8).
REQ-002 SHALL have parameter COLS, default 4, board column count (2..8).
REQ-003 SHALL have parameter TW, default 4, tile width in bits; value 0 = empty, value k = tile 2^k.
REQ-004 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid  input  1  move request.
REQ-007 SHALL have port cmd_dir  input  2  0=up, 1=down, 2=left, 3=right; sampled on accept.
REQ-008 SHALL have port cmd_ready  output  1  move may be accepted this cycle.
REQ-009 SHALL have port load_valid  input  1  overwrite board with load_board.
REQ-010 SHALL have port load_board  input  ROWS*COLS*TW  tile i=r*COLS+c at bits [i*TW +: TW].
REQ-011 SHALL have port board  output  ROWS*COLS*TW  committed board, same packing.
REQ-012 SHALL have port busy  output  1  high while a move is in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a move commits.
REQ-014 SHALL have port moved  output  1  last committed move changed the board.
REQ-015 SHALL have port merge_cnt  output  8  merges performed by last committed move.

Function
REQ-016 SHALL implement FSM IDLE -> SHIFT -> DONE -> IDLE.
REQ-017 SHALL assert cmd_ready only in IDLE with load_valid low; accept = cmd_valid && cmd_ready.
REQ-018 On accept at edge E0, SHALL latch cmd_dir, copy board to working register, clear line index, enter SHIFT.
REQ-019 SHALL set line count L = COLS for up/down, ROWS for left/right.
REQ-020 In SHIFT, SHALL process exactly one line per cycle, line j written to working register at edge E(j+1), j = 0..L-1.
REQ-021 Per line SHALL compact non-zero tiles toward destination edge (up: r=0, down: r=ROWS-1, left: c=0, right: c=COLS-1), preserving order.
REQ-022 SHALL merge adjacent equal non-zero pairs scanning from destination edge outward; result value k+1; each tile merges at most once per move.
REQ-023 SHALL NOT merge tiles of value 2^TW-1 (saturation; no wrap to 0).
REQ-024 After line L-1, SHALL enter DONE: at edge E(L+1) board <= working register, moved <= (new != old), merge_cnt <= total merges; done high for that one cycle.
REQ-025 Latency SHALL be L+1 cycles from accept edge to done pulse; board SHALL hold pre-move value until commit.
REQ-026 SHALL return to IDLE the edge after DONE; busy high in SHIFT and DONE only.
REQ-027 In IDLE, load_valid SHALL load board at next edge and clear moved, merge_cnt; load wins over simultaneous cmd_valid (cmd not accepted).
REQ-028 load_valid and cmd_valid outside IDLE SHALL be ignored; no queuing.
REQ-029 A move with no change SHALL still take L+1 cycles and pulse done with moved=0.
REQ-030 ROWS*COLS SHALL be <= 64 so merge_cnt cannot overflow.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, board all 0, working register 0, done 0, moved 0, merge_cnt 0, busy 0, cmd_ready 0.
REQ-032 Reset mid-move SHALL abort without commit; cmd_ready SHALL rise the first cycle after rst_n deasserts.

Verification
REQ-033 Left merge: 4x4, row0 = [1,1,1,0], other rows 0, cmd left -> row0 = [2,1,0,0], moved=1, merge_cnt=1, done exactly 5 cycles after accept, busy high 5 cycles.
REQ-034 Double merge: row0 = [2,2,2,2], cmd right -> row0 = [0,0,3,3], merge_cnt=2; no chain merge to 4.
REQ-035 No-op and saturation: row0 = [1,2,3,4] left, then row0 = [15,15,0,0] left -> both unchanged, moved=0, merge_cnt=0, done still pulses.
REQ-036 Column move: column 0 = [0,1,0,1] top-to-bottom, cmd up -> column 0 = [2,0,0,0]; cmd down on fresh copy -> [0,0,0,2].
REQ-037 Contention: load_valid and cmd_valid both high in IDLE -> board = load_board, no move accepted, done stays 0; cmd_valid during SHIFT ignored.
REQ-038 Reset mid-move: assert rst_n low at cycle 2 of SHIFT -> board = 0, done never pulses, cmd_ready high one cycle after release.
